// File: rtl/dispatch_ctrl.sv
// dispatch_ctrl: routes one master word to a decryption channel demux, holding select through byte serialisation
module dispatch_ctrl #(
  parameter int MST_DWIDTH = 32,
  parameter int SYS_DWIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_sys,
  input  logic                  rst,
  input  logic [MST_DWIDTH-1:0] data_i,
  input  logic [1:0]            alg_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [2:0]            en_i,
  input  logic [2:0]            busy_i,
  output logic [MST_DWIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic [1:0]            select_o,
  output logic [CNT_WIDTH-1:0]  words0_o,
  output logic [CNT_WIDTH-1:0]  words1_o,
  output logic [CNT_WIDTH-1:0]  words2_o,
  output logic [CNT_WIDTH-1:0]  err_cnt_o
);
  localparam int BYTES = MST_DWIDTH / SYS_DWIDTH;
  localparam int CW = $clog2(BYTES + 1);
  typedef enum logic [1:0] {IDLE, WAIT_CH, ISSUE, DRAIN} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [CNT_WIDTH-1:0] words [3];
  logic [3:0] en_x, busy_x;
  logic accept, drop, done;
  // channel 3 does not exist, so it reads as disabled and never busy
  assign en_x = {1'b0, en_i};
  assign busy_x = {1'b0, busy_i};
  assign ready_o = state == IDLE && !rst;
  assign accept = valid_i && ready_o;
  assign drop = !en_x[alg_i];
  assign done = state == DRAIN && cnt == CW'(BYTES);
  assign words0_o = words[0];
  assign words1_o = words[1];
  assign words2_o = words[2];
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = accept && !drop ? (busy_x[alg_i] ? WAIT_CH : ISSUE) : IDLE;
      WAIT_CH: nxt = busy_x[select_o] ? WAIT_CH : ISSUE;
      ISSUE:   nxt = DRAIN;
      default: nxt = done ? IDLE : DRAIN;
    endcase
  end
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      data_o    <= '0;
      valid_o   <= 1'b0;
      select_o  <= '0;
      err_cnt_o <= '0;
      for (int i = 0; i < 3; i++) words[i] <= '0;
    end else begin
      state     <= nxt;
      valid_o   <= nxt == ISSUE;
      cnt       <= state == DRAIN && !done ? cnt + 1'b1 : '0;
      if (accept && !drop) begin
        data_o   <= data_i;
        select_o <= alg_i;
      end
      err_cnt_o <= err_cnt_o + CNT_WIDTH'(accept && drop && !(&err_cnt_o));
      for (int i = 0; i < 3; i++)
        words[i] <= words[i] + CNT_WIDTH'(done && select_o == 2'(i) && !(&words[i]));
    end
  end
endmodule

// File: tb/tb_dispatch_ctrl.sv
// tb_dispatch_ctrl: directed and randomized transfers checked against a transaction-level model
module tb_dispatch_ctrl;
  localparam int CW = 4;
  logic clk_sys = 1'b0;
  logic rst = 1'b1;
  logic [31:0] data_i = '0;
  logic [1:0] alg_i = '0;
  logic valid_i = 1'b0;
  logic [2:0] en_i = '0, busy_i = '0;
  logic ready_o, valid_o;
  logic [31:0] data_o;
  logic [1:0] select_o;
  logic [CW-1:0] words0_o, words1_o, words2_o, err_cnt_o;
  dispatch_ctrl #(.MST_DWIDTH(32), .SYS_DWIDTH(8), .CNT_WIDTH(CW)) dut (
    .clk_sys(clk_sys), .rst(rst), .data_i(data_i), .alg_i(alg_i), .valid_i(valid_i),
    .ready_o(ready_o), .en_i(en_i), .busy_i(busy_i), .data_o(data_o), .valid_o(valid_o),
    .select_o(select_o), .words0_o(words0_o), .words1_o(words1_o), .words2_o(words2_o),
    .err_cnt_o(err_cnt_o)
  );
  always #5 clk_sys = ~clk_sys;
  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;
  int total = 0, bad = 0;
  logic [CW-1:0] m_words [3];
  logic [CW-1:0] m_err;
  logic [1:0] m_sel;
  logic [31:0] m_data;
  int v0, v1, v2;
  function automatic logic [CW-1:0] sat(input logic [CW-1:0] v);
    return &v ? v : v + 1'b1;
  endfunction
  function automatic logic [CW-1:0] words_of(input int i);
    return i == 0 ? words0_o : i == 1 ? words1_o : words2_o;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic chk_cnt();
    for (int i = 0; i < 3; i++) chk($sformatf("words%0d", i), words_of(i), m_words[i]);
    chk("err_cnt", err_cnt_o, m_err);
  endtask
  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_words[i] = '0;
    m_err = '0;
    m_sel = '0;
    m_data = '0;
  endtask
  // one transfer: channel a busy for the first b sampled edges, then issue and drain
  task automatic xfer(input logic [31:0] d, input logic [1:0] a, input logic [2:0] en,
                      input int b, input bit hold, output int vcyc);
    int w = 0;
    bit drop;
    vcyc = -1;
    while (ready_o !== 1'b1 && w < 50) begin
      @(negedge clk_sys);
      w++;
    end
    chk("ready_wait", ready_o, 1);
    drop = (a == 2'd3) ? 1'b1 : !en[a];
    data_i = d;
    alg_i = a;
    en_i = en;
    valid_i = 1'b1;
    busy_i = 3'($urandom);
    if (a != 2'd3) busy_i[a] = b > 0;
    if (drop) begin
      @(negedge clk_sys);
      valid_i = hold;
      m_err = sat(m_err);
      chk("drop_valid", valid_o, 0);
      chk("drop_ready", ready_o, 1);
      chk("drop_err", err_cnt_o, m_err);
      chk("drop_sel", select_o, m_sel);
      chk("drop_data", data_o, m_data);
      return;
    end
    m_sel = a;
    m_data = d;
    for (int k = 0; k <= b + 6; k++) begin
      @(negedge clk_sys);
      if (k == b) vcyc = cyc;
      chk($sformatf("valid_k%0d", k), valid_o, k == b);
      chk($sformatf("ready_k%0d", k), ready_o, k >= b + 6);
      chk($sformatf("sel_k%0d", k), select_o, a);
      if (k >= b) chk($sformatf("data_k%0d", k), data_o, d);
      if (k == b + 6) begin
        m_words[a] = sat(m_words[a]);
        chk_cnt();
      end
      valid_i = hold;
      data_i = $urandom;
      alg_i = 2'($urandom);
      en_i = 3'($urandom);
      busy_i = 3'($urandom);
      if (k + 1 <= b) busy_i[a] = k + 1 < b;
    end
  endtask
  initial begin
    model_reset();
    #12;
    chk("rst_ready", ready_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_sel", select_o, 0);
    chk("rst_data", data_o, 0);
    chk_cnt();
    @(negedge clk_sys);
    rst = 1'b0;
    @(negedge clk_sys);
    chk("idle_ready", ready_o, 1);
    xfer(32'h44332211, 2'd1, 3'b111, 0, 1'b0, v0);
    xfer(32'hDEADBEEF, 2'd3, 3'b111, 0, 1'b0, v0);
    xfer($urandom, 2'd2, 3'b011, 0, 1'b0, v0);
    chk("err_two", err_cnt_o, 2);
    xfer($urandom, 2'd0, 3'b111, 5, 1'b0, v0);
    xfer($urandom, 2'd0, 3'b111, 0, 1'b1, v0);
    xfer($urandom, 2'd1, 3'b111, 0, 1'b1, v1);
    xfer($urandom, 2'd2, 3'b111, 0, 1'b1, v2);
    valid_i = 1'b0;
    chk("spacing01", v1 - v0, 7);
    chk("spacing12", v2 - v1, 7);
    data_i = 32'hCAFE0001;
    alg_i = 2'd2;
    en_i = 3'b111;
    busy_i = '0;
    valid_i = 1'b1;
    @(negedge clk_sys);
    valid_i = 1'b0;
    repeat (3) @(negedge clk_sys);
    chk("drain_sel", select_o, 2);
    #1 rst = 1'b1;
    #1;
    model_reset();
    chk("arst_valid", valid_o, 0);
    chk("arst_sel", select_o, 0);
    chk("arst_data", data_o, 0);
    chk("arst_ready", ready_o, 0);
    chk_cnt();
    @(negedge clk_sys);
    rst = 1'b0;
    @(negedge clk_sys);
    chk("post_rst_ready", ready_o, 1);
    xfer($urandom, 2'd1, 3'b111, 1, 1'b0, v0);
    for (int i = 0; i < 16; i++) xfer($urandom, 2'd0, 3'($urandom) | 3'b001, 0, 1'b0, v0);
    chk("words0_sat", words0_o, 4'hf);
    for (int i = 0; i < 16; i++) xfer($urandom, 2'd3, 3'($urandom), 0, 1'b1, v0);
    valid_i = 1'b0;
    chk("err_sat", err_cnt_o, 4'hf);
    for (int i = 0; i < 25; i++)
      xfer($urandom, 2'($urandom_range(0, 3)), 3'($urandom), $urandom_range(0, 3), 1'($urandom), v0);
    valid_i = 1'b0;
    @(negedge clk_sys);
    chk_cnt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
